// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants and the skid-buffer occupancy encoding.
// Used by pipe_skid_buf and ifid_pipe_reg.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INST_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Encoding mirrors {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } skid_state_e;

    function automatic logic state_has_main(input skid_state_e st);
        return st[0];
    endfunction

    function automatic logic state_has_skid(input skid_state_e st);
        return st[1];
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with valid/ready handshake and synchronous flush.
// in_ready depends only on the occupancy flops, never on out_ready.
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int unsigned       WIDTH      = 96,
    parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
    parameter logic [WIDTH-1:0]  FLUSH_MASK = '0,
    parameter logic [WIDTH-1:0]  FLUSH_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             consume;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (accept) state_d = StOne;
                StOne: begin
                    if (accept && !consume) begin
                        state_d = StFull;
                    end else if (!accept && consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull:  if (consume) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        in_ready  = !state_has_skid(state_q);
        out_valid = state_has_main(state_q);
    end

    // A flush only rewrites the fields selected by FLUSH_MASK; the rest hold.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = (main_q & ~FLUSH_MASK) | (FLUSH_VAL & FLUSH_MASK);
        end else if (state_q == StFull) begin
            if (consume) main_d = skid_q;
        end else if (accept) begin
            if (consume || (state_q == StEmpty)) begin
                main_d = in_data;
            end else begin
                skid_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register built on pipe_skid_buf; flush clears inst to NOP, pcs hold.
// Optional stall counter port stall_cnt is enabled by defining IFID_PERF_CNT_EN.
module ifid_pipe_reg
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [ADDR_W-1:0] if_pc_plus_4,
    input  logic [INST_W-1:0] if_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus_4,
    output logic [INST_W-1:0] id_inst
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned         BUS_W      = 2 * ADDR_W + INST_W;
    localparam logic [BUS_W-1:0]    RESET_BUS  = {RESET_PC, RESET_PC, NOP_INST};
    localparam logic [BUS_W-1:0]    FLUSH_MASK = {{(2 * ADDR_W){1'b0}}, {INST_W{1'b1}}};
    localparam logic [BUS_W-1:0]    FLUSH_BUS  = {{(2 * ADDR_W){1'b0}}, NOP_INST};

    logic [BUS_W-1:0] in_bus;
    logic [BUS_W-1:0] out_bus;

    assign in_bus = {if_pc, if_pc_plus_4, if_inst};

    pipe_skid_buf #(
        .WIDTH      (BUS_W),
        .RESET_VAL  (RESET_BUS),
        .FLUSH_MASK (FLUSH_MASK),
        .FLUSH_VAL  (FLUSH_BUS)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (if_valid),
        .in_ready  (if_ready),
        .in_data   (in_bus),
        .out_valid (id_valid),
        .out_ready (id_ready),
        .out_data  (out_bus)
    );

    assign id_pc        = out_bus[BUS_W-1 -: ADDR_W];
    assign id_pc_plus_4 = out_bus[INST_W +: ADDR_W];
    assign id_inst      = out_bus[INST_W-1:0];

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating; deliberately survives flush so stalls across redirects accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (id_valid && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Randomized self-checking bench for ifid_pipe_reg against a queue-based reference model.
module tb_ifid_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        id_ready = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_pc_plus_4 = '0;
    logic [31:0] if_inst = '0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus_4;
    logic [31:0] id_inst;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    ifid_pipe_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_pc_plus_4 (if_pc_plus_4),
        .if_inst      (if_inst),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_pc_plus_4 (id_pc_plus_4),
        .id_inst      (id_inst)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    ent_t        disp;
    logic [31:0] m_stall;
    logic [31:0] seq = '0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        disp    = '{pc: 32'h0000_3000, pc4: 32'h0000_3000, inst: 32'h0};
        m_stall = '0;
    endtask

    // Queue of held entries (oldest first), at most two; outputs show the oldest.
    task automatic model_step(input logic v, input logic rdy, input logic fl, input ent_t e);
        bit acc;
        bit con;
        acc = v && (q.size() < 2);
        con = (q.size() > 0) && rdy;
        if ((q.size() > 0) && !rdy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (fl) begin
            q.delete();
            disp.inst = 32'h0;
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (q.size() > 0) disp = q[0];
        end
    endtask

    task automatic compare_all();
        check_eq("id_valid", 32'(id_valid), 32'(q.size() > 0));
        check_eq("if_ready", 32'(if_ready), 32'(q.size() < 2));
        check_eq("id_pc", id_pc, disp.pc);
        check_eq("id_pc_plus_4", id_pc_plus_4, disp.pc4);
        check_eq("id_inst", id_inst, disp.inst);
`ifdef IFID_PERF_CNT_EN
        check_eq("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    // Called just after a negedge; drives inputs, advances the model over one edge, checks.
    task automatic step(input logic v, input logic rdy, input logic fl, input logic [31:0] pc);
        ent_t e;
        seq++;
        e.pc   = pc;
        e.pc4  = pc + 32'd4;
        e.inst = seq;
        if_valid     = v;
        id_ready     = rdy;
        flush        = fl;
        if_pc        = pc;
        if_pc_plus_4 = pc + 32'd4;
        if_inst      = seq;
        model_step(v, rdy, fl, e);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Streaming at full rate
        step(1'b1, 1'b1, 1'b0, 32'h3000);
        check_eq("stream0_pc", id_pc, 32'h3000);
        step(1'b1, 1'b1, 1'b0, 32'h3004);
        check_eq("stream1_pc", id_pc, 32'h3004);
        step(1'b1, 1'b1, 1'b0, 32'h3008);
        check_eq("stream2_pc", id_pc, 32'h3008);
        check_eq("stream_rdy", 32'(if_ready), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Back-pressure fills the skid, then drains in order
        step(1'b1, 1'b0, 1'b0, 32'h3000);
        step(1'b1, 1'b0, 1'b0, 32'h3004);
        check_eq("bp_full_rdy", 32'(if_ready), 32'd0);
        check_eq("bp_hold_pc", id_pc, 32'h3000);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("bp_second_pc", id_pc, 32'h3004);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("bp_drained", 32'(id_valid), 32'd0);

        // Flush while full, with a simultaneous upstream offer
        step(1'b1, 1'b0, 1'b0, 32'h3008);
        step(1'b1, 1'b0, 1'b0, 32'h300C);
        step(1'b1, 1'b0, 1'b1, 32'h3010);
        check_eq("fl_valid", 32'(id_valid), 32'd0);
        check_eq("fl_inst", id_inst, 32'h0);
        check_eq("fl_pc_hold", id_pc, 32'h3008);
        check_eq("fl_rdy", 32'(if_ready), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("fl_no_3010", 32'(id_valid), 32'd0);

        // Asynchronous reset mid-cycle while full
        step(1'b1, 1'b0, 1'b0, 32'h3100);
        step(1'b1, 1'b0, 1'b0, 32'h3104);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(id_valid), 32'd0);
        check_eq("rst_rdy", 32'(if_ready), 32'd1);
        check_eq("rst_pc", id_pc, 32'h3000);
        check_eq("rst_pc4", id_pc_plus_4, 32'h3000);
        check_eq("rst_inst", id_inst, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef IFID_PERF_CNT_EN
        step(1'b1, 1'b0, 1'b0, 32'h3200);
        repeat (7) step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("stall7", stall_cnt, 32'd7);
        step(1'b0, 1'b1, 1'b0, 32'h0);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 31) == 0), ($urandom & 32'hFFFF_FFFC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
